// File: rtl/trans_fifo_v2.sv
// trans_fifo_v2: transactional FIFO with speculative write/read pointers, commit and rollback per side.
// Optional macro TRANS_FIFO_SAME_CYCLE_COMMIT_EN folds a handshake on a Done cycle into that transaction.
module trans_fifo_v2 #(
  parameter int unsigned DATA_WID        = 8,
  parameter int unsigned DEPTH           = 64,
  parameter int          ALMOST_FULL_LVL = DEPTH - 4,
  parameter int unsigned CNT_WID         = $clog2(DEPTH + 1)
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                fillTransDone,
  input  logic                fillTransSuccess,
  input  logic                dataValid,
  input  logic [DATA_WID-1:0] dataIn,
  output logic                full,
  output logic                almostFull,
  output logic [CNT_WID-1:0]  freeSpace,
  input  logic                popTransDone,
  input  logic                popTransSuccess,
  input  logic                popData,
  output logic                dataAvailable,
  output logic [DATA_WID-1:0] dataOut,
  output logic [CNT_WID-1:0]  availCount
);

  localparam int unsigned IDX_WID = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_WID = IDX_WID + 1;
  localparam int unsigned AF_LVL  = (ALMOST_FULL_LVL <= 0) ? 32'd0 : 32'(ALMOST_FULL_LVL);

  // Pointer layout: {lap, index}
  typedef logic [PTR_WID-1:0] ptr_t;

  logic [DATA_WID-1:0] mem [DEPTH];

  ptr_t wrCommit, wrTrans, rdCommit, rdTrans;
  ptr_t wrCommitNxt, wrTransNxt, rdCommitNxt, rdTransNxt;
  logic [CNT_WID-1:0] usedWr, availCnt;
  logic wrAccept, rdAccept, wrAdv, rdAdv;

  function automatic ptr_t ptrInc(input ptr_t p);
    if (p[IDX_WID-1:0] == IDX_WID'(DEPTH - 1))
      return {~p[IDX_WID], IDX_WID'(0)};
    return p + PTR_WID'(1);
  endfunction

  // Distance a - b in entries; the lap bit disambiguates equal indices.
  function automatic logic [CNT_WID-1:0] ptrDist(input ptr_t a, input ptr_t b);
    logic [CNT_WID-1:0] ai;
    logic [CNT_WID-1:0] bi;
    ai = CNT_WID'(a[IDX_WID-1:0]);
    bi = CNT_WID'(b[IDX_WID-1:0]);
    if (a[IDX_WID] == b[IDX_WID])
      return ai - bi;
    return (CNT_WID'(DEPTH) - bi) + ai;
  endfunction

  assign usedWr        = ptrDist(wrTrans, rdCommit);
  assign availCnt      = ptrDist(wrCommit, rdTrans);
  assign full          = (usedWr == CNT_WID'(DEPTH));
  assign almostFull    = (32'(usedWr) >= AF_LVL);
  assign freeSpace     = CNT_WID'(DEPTH) - usedWr;
  assign availCount    = availCnt;
  assign dataAvailable = (availCnt != '0);
  assign dataOut       = mem[rdTrans[IDX_WID-1:0]];

  always_comb begin
    wrAccept = dataValid && !full;
    rdAccept = popData && dataAvailable;
`ifdef TRANS_FIFO_SAME_CYCLE_COMMIT_EN
    wrAdv = wrAccept;
    rdAdv = rdAccept;
`else
    wrAdv = wrAccept && !fillTransDone;
    rdAdv = rdAccept && !popTransDone;
`endif
    wrTransNxt  = wrAdv ? ptrInc(wrTrans) : wrTrans;
    wrCommitNxt = wrCommit;
    rdTransNxt  = rdAdv ? ptrInc(rdTrans) : rdTrans;
    rdCommitNxt = rdCommit;

    // Commit takes the advanced pointer; rollback returns to the last commit point.
    if (fillTransDone) begin
      if (fillTransSuccess) wrCommitNxt = wrTransNxt;
      else                  wrTransNxt  = wrCommit;
    end
    if (popTransDone) begin
      if (popTransSuccess) rdCommitNxt = rdTransNxt;
      else                 rdTransNxt  = rdCommit;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wrCommit <= '0;
      wrTrans  <= '0;
      rdCommit <= '0;
      rdTrans  <= '0;
    end else begin
      wrCommit <= wrCommitNxt;
      wrTrans  <= wrTransNxt;
      rdCommit <= rdCommitNxt;
      rdTrans  <= rdTransNxt;
    end
  end

  // Storage is never reset; a write slot is always outside committed data.
  always_ff @(posedge CLK) begin
    if (wrAdv)
      mem[wrTrans[IDX_WID-1:0]] <= dataIn;
  end

endmodule

// File: tb/tb_trans_fifo_v2.sv
// tb_trans_fifo_v2: vector table, multi-lap sequence and randomized run against a queue-based model.
module tb_trans_fifo_v2;

  localparam int DW     = 8;
  localparam int DEPTH  = 5;
  localparam int AF_LVL = 3;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          rst_n;
  logic          fillTransDone, fillTransSuccess, dataValid;
  logic [DW-1:0] dataIn;
  logic          full, almostFull;
  logic [CW-1:0] freeSpace;
  logic          popTransDone, popTransSuccess, popData;
  logic          dataAvailable;
  logic [DW-1:0] dataOut;
  logic [CW-1:0] availCount;

  int nChecks = 0;
  int nFails  = 0;

  always #5 CLK = ~CLK;

  trans_fifo_v2 #(
    .DATA_WID(DW), .DEPTH(DEPTH), .ALMOST_FULL_LVL(AF_LVL)
  ) dut (
    .CLK(CLK), .rst_n(rst_n),
    .fillTransDone(fillTransDone), .fillTransSuccess(fillTransSuccess),
    .dataValid(dataValid), .dataIn(dataIn),
    .full(full), .almostFull(almostFull), .freeSpace(freeSpace),
    .popTransDone(popTransDone), .popTransSuccess(popTransSuccess),
    .popData(popData), .dataAvailable(dataAvailable),
    .dataOut(dataOut), .availCount(availCount)
  );

  // Reference model: committed words in order, pending writes, count of speculatively read words.
  logic [DW-1:0] commitQ[$];
  logic [DW-1:0] wrPend[$];
  int rdSpec;

  task automatic modelReset();
    commitQ.delete();
    wrPend.delete();
    rdSpec = 0;
  endtask

  task automatic modelStep(input bit fd, input bit fs, input bit dv, input logic [DW-1:0] din,
                           input bit pd, input bit ps, input bit pp);
    int used;
    int avail;
    bit wAcc;
    bit rAcc;
    used  = commitQ.size() + wrPend.size();
    avail = commitQ.size() - rdSpec;
    wAcc  = dv && (used < DEPTH);
    rAcc  = pp && (avail > 0);
`ifndef TRANS_FIFO_SAME_CYCLE_COMMIT_EN
    if (fd) wAcc = 1'b0;
    if (pd) rAcc = 1'b0;
`endif
    if (wAcc) wrPend.push_back(din);
    if (rAcc) rdSpec++;
    if (pd) begin
      if (ps) repeat (rdSpec) void'(commitQ.pop_front());
      rdSpec = 0;
    end
    if (fd) begin
      if (fs) foreach (wrPend[i]) commitQ.push_back(wrPend[i]);
      wrPend.delete();
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chkModel(input string tag);
    int used;
    int avail;
    used  = commitQ.size() + wrPend.size();
    avail = commitQ.size() - rdSpec;
    chk({tag, ".freeSpace"}, int'(freeSpace), DEPTH - used);
    chk({tag, ".availCount"}, int'(availCount), avail);
    chk({tag, ".full"}, int'(full), int'(used == DEPTH));
    chk({tag, ".almostFull"}, int'(almostFull), int'(used >= AF_LVL));
    chk({tag, ".dataAvailable"}, int'(dataAvailable), int'(avail != 0));
    if (avail != 0) chk({tag, ".dataOut"}, int'(dataOut), int'(commitQ[rdSpec]));
  endtask

  // Drive one cycle at the falling edge; return at the next falling edge.
  task automatic cyc(input bit fd, input bit fs, input bit dv, input logic [DW-1:0] din,
                     input bit pd, input bit ps, input bit pp);
    fillTransDone = fd; fillTransSuccess = fs; dataValid = dv; dataIn = din;
    popTransDone = pd; popTransSuccess = ps; popData = pp;
    modelStep(fd, fs, dv, din, pd, ps, pp);
    @(negedge CLK);
  endtask

  typedef struct {
    bit fd, fs, dv;
    logic [DW-1:0] din;
    bit pd, ps, pp;
    int free, avail;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit fd, input bit fs, input bit dv, input logic [DW-1:0] din,
                              input bit pd, input bit ps, input bit pp,
                              input int free, input int avail, input logic [DW-1:0] dout);
    vec_t v;
    v.fd = fd; v.fs = fs; v.dv = dv; v.din = din;
    v.pd = pd; v.ps = ps; v.pp = pp;
    v.free = free; v.avail = avail; v.dout = dout;
    return v;
  endfunction

  initial begin
    vec_t v;
    string nm;
    rst_n = 1'b0;
    fillTransDone = 0; fillTransSuccess = 0; dataValid = 0; dataIn = '0;
    popTransDone = 0; popTransSuccess = 0; popData = 0;
    modelReset();
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);

    chk("reset.freeSpace", int'(freeSpace), 5);
    chk("reset.availCount", int'(availCount), 0);
    chk("reset.full", int'(full), 0);
    chk("reset.almostFull", int'(almostFull), 0);
    chk("reset.dataAvailable", int'(dataAvailable), 0);

    //            fd fs dv din    pd ps pp free avail dout
    vecs.push_back(mk(0,0,1,8'h11, 0,0,0, 4,0,8'h00));
    vecs.push_back(mk(0,0,1,8'h22, 0,0,0, 3,0,8'h00));
    vecs.push_back(mk(0,0,1,8'h33, 0,0,0, 2,0,8'h00));
    vecs.push_back(mk(1,1,0,8'h00, 0,0,0, 2,3,8'h11));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 2,2,8'h22));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 2,1,8'h33));
    vecs.push_back(mk(0,0,0,8'h00, 1,1,0, 4,1,8'h33));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 4,0,8'h00));
    vecs.push_back(mk(0,0,0,8'h00, 1,1,0, 5,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hA1, 0,0,0, 4,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hA2, 0,0,0, 3,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hA3, 0,0,0, 2,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hA4, 0,0,0, 1,0,8'h00));
    vecs.push_back(mk(1,0,0,8'h00, 0,0,0, 5,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hB1, 0,0,0, 4,0,8'h00));
    vecs.push_back(mk(1,1,0,8'h00, 0,0,0, 4,1,8'hB1));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 4,0,8'h00));
    vecs.push_back(mk(0,0,0,8'h00, 1,1,0, 5,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hC1, 0,0,0, 4,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hC2, 0,0,0, 3,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hC3, 0,0,0, 2,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hC4, 0,0,0, 1,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hC5, 0,0,0, 0,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hC6, 0,0,0, 0,0,8'h00));
    vecs.push_back(mk(1,1,0,8'h00, 0,0,0, 0,5,8'hC1));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 0,4,8'hC2));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 0,3,8'hC3));
    vecs.push_back(mk(0,0,0,8'h00, 1,0,0, 0,5,8'hC1));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 0,4,8'hC2));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 0,3,8'hC3));
    vecs.push_back(mk(0,0,0,8'h00, 1,1,0, 2,3,8'hC3));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 2,2,8'hC4));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 2,1,8'hC5));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 2,0,8'h00));
    vecs.push_back(mk(0,0,0,8'h00, 1,1,0, 5,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hD1, 0,0,0, 4,0,8'h00));
    vecs.push_back(mk(0,0,1,8'hD2, 0,0,0, 3,0,8'h00));
`ifdef TRANS_FIFO_SAME_CYCLE_COMMIT_EN
    vecs.push_back(mk(1,1,1,8'h44, 0,0,0, 2,3,8'hD1));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 2,2,8'hD2));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 2,1,8'h44));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 2,0,8'h00));
`else
    vecs.push_back(mk(1,1,1,8'h44, 0,0,0, 3,2,8'hD1));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 3,1,8'hD2));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 3,0,8'h00));
    vecs.push_back(mk(0,0,0,8'h00, 0,0,1, 3,0,8'h00));
`endif
    vecs.push_back(mk(0,0,0,8'h00, 1,1,0, 5,0,8'h00));

    foreach (vecs[i]) begin
      v = vecs[i];
      cyc(v.fd, v.fs, v.dv, v.din, v.pd, v.ps, v.pp);
      nm = $sformatf("vec%0d", i);
      chk({nm, ".freeSpace"}, int'(freeSpace), v.free);
      chk({nm, ".availCount"}, int'(availCount), v.avail);
      chk({nm, ".full"}, int'(full), int'(v.free == 0));
      chk({nm, ".almostFull"}, int'(almostFull), int'((DEPTH - v.free) >= AF_LVL));
      chk({nm, ".dataAvailable"}, int'(dataAvailable), int'(v.avail != 0));
      if (v.avail != 0) chk({nm, ".dataOut"}, int'(dataOut), int'(v.dout));
    end

    // Many laps of 3-word transactions on a non-power-of-two depth.
    for (int k = 0; k < 23; k++) begin
      for (int j = 0; j < 3; j++) cyc(0, 0, 1, 8'(k * 3 + j + 1), 0, 0, 0);
      cyc(1, 1, 0, 8'h00, 0, 0, 0);
      chk($sformatf("lap%0d.availCount", k), int'(availCount), 3);
      chk($sformatf("lap%0d.freeSpace", k), int'(freeSpace), 2);
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("lap%0d.dataOut%0d", k, j), int'(dataOut), (k * 3 + j + 1) % 256);
        cyc(0, 0, 0, 8'h00, 0, 0, 1);
      end
      cyc(0, 0, 0, 8'h00, 1, 1, 0);
      chk($sformatf("lap%0d.freeEnd", k), int'(freeSpace), 5);
    end

    chkModel("preRandom");
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
          8'($urandom), $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 5);
      chkModel($sformatf("rand%0d", n));
    end

    // Asynchronous reset in the middle of the low clock phase.
    cyc(0, 0, 1, 8'h5A, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    chk("asyncRst.freeSpace", int'(freeSpace), 5);
    chk("asyncRst.availCount", int'(availCount), 0);
    chk("asyncRst.full", int'(full), 0);
    chk("asyncRst.dataAvailable", int'(dataAvailable), 0);
    dataValid = 0;
    @(negedge CLK);
    rst_n = 1'b1;
    cyc(0, 0, 0, 8'h00, 0, 0, 0);
    chkModel("postRst");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
